// File: rtl/axi_multicon_n.sv
// AXI4 64-bit slave with GPIO outputs, a prescaled 64-bit mtime counter and NUM_TIMERS
// compare channels with per-channel interrupt enables.
module axi_multicon_n #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned GPIO_WIDTH = 8,
  parameter int unsigned NUM_TIMERS = 2,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [63:0]           i_wdata,
  input  logic [7:0]            i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [63:0]           o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [GPIO_WIDTH-1:0] o_gpio,
  output logic [NUM_TIMERS-1:0] o_timer_irq
);

  localparam int unsigned IdxW    = ADDR_WIDTH - 3;
  localparam int unsigned NumRegs = 4 + NUM_TIMERS;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam logic [63:0] IdValue = {32'h0001_0000, 8'(NUM_TIMERS), 8'(GPIO_WIDTH), 16'h0};

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
  typedef enum logic {StRIdle, StRData} r_state_e;

  logic [GPIO_WIDTH-1:0] gpio_q;
  logic [63:0]           mtime_q;
  logic [15:0]           prescale_q, pcnt_q;
  logic [NUM_TIMERS-1:0] irq_en_q, irq_q;
  logic [63:0]           cmp_q [NUM_TIMERS];

  function automatic logic idx_ok(input logic [IdxW-1:0] idx);
    return 32'(idx) < NumRegs;
  endfunction

  function automatic logic [63:0] reg_value(input logic [IdxW-1:0] idx);
    logic [63:0] v;
    v = '0;
    if (idx == IdxW'(0))      v = IdValue;
    else if (idx == IdxW'(1)) v = 64'(gpio_q);
    else if (idx == IdxW'(2)) v = mtime_q;
    else if (idx == IdxW'(3)) v = 64'({irq_en_q, prescale_q});
    for (int i = 0; i < int'(NUM_TIMERS); i++) begin
      if (idx == IdxW'(4 + i)) v = cmp_q[i];
    end
    return v;
  endfunction

  function automatic logic [63:0] strb_merge(input logic [63:0] old, input logic [63:0] data,
                                             input logic [7:0] strb);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old[b*8 +: 8];
    return v;
  endfunction

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   awid_q;
  logic [IdxW-1:0]       widx_q;
  logic [7:0]            awlen_q;
  logic                  wr_en;
  logic [63:0]           wr_word;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^{i_awaddr[2:0], i_araddr[2:0]};

  // Bursts never modify state; they only earn a SLVERR.
  assign wr_en   = (w_state_q == StWData) && i_wvalid && (awlen_q == 8'd0) && idx_ok(widx_q);
  assign wr_word = strb_merge(reg_value(widx_q), i_wdata, i_wstrb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state_q <= StWIdle;
    else     w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      StWIdle: if (i_awvalid)            w_state_d = StWData;
      StWData: if (i_wvalid && i_wlast)  w_state_d = StWResp;
      StWResp: if (i_bready)             w_state_d = StWIdle;
      default:                           w_state_d = StWIdle;
    endcase
  end

  always_comb begin
    o_awready = (w_state_q == StWIdle);
    o_wready  = (w_state_q == StWData);
    o_bvalid  = (w_state_q == StWResp);
    o_bid     = awid_q;
    o_bresp   = (o_bvalid && (awlen_q != 8'd0 || !idx_ok(widx_q))) ? RespSlvErr : RespOkay;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awid_q  <= '0;
      widx_q  <= '0;
      awlen_q <= '0;
    end else if (w_state_q == StWIdle && i_awvalid) begin
      awid_q  <= i_awid;
      widx_q  <= i_awaddr[ADDR_WIDTH-1:3];
      awlen_q <= i_awlen;
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [7:0]            arlen_q, rcnt_q;
  logic [63:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic [IdxW-1:0]       ridx;

  assign ridx = i_araddr[ADDR_WIDTH-1:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state_q <= StRIdle;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      StRIdle: if (i_arvalid)                       r_state_d = StRData;
      StRData: if (i_rready && rcnt_q == arlen_q)   r_state_d = StRIdle;
      default:                                      r_state_d = StRIdle;
    endcase
  end

  always_comb begin
    o_arready = (r_state_q == StRIdle);
    o_rvalid  = (r_state_q == StRData);
    o_rlast   = o_rvalid && (rcnt_q == arlen_q);
    o_rid     = arid_q;
    o_rdata   = rdata_q;
    o_rresp   = o_rvalid ? rresp_q : RespOkay;
  end

  // Data is captured at the AR handshake, so a colliding write is not yet visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arid_q  <= '0;
      arlen_q <= '0;
      rcnt_q  <= '0;
      rdata_q <= '0;
      rresp_q <= RespOkay;
    end else if (r_state_q == StRIdle && i_arvalid) begin
      arid_q  <= i_arid;
      arlen_q <= i_arlen;
      rcnt_q  <= '0;
      rdata_q <= (i_arlen == 8'd0 && idx_ok(ridx)) ? reg_value(ridx) : '0;
      rresp_q <= (i_arlen != 8'd0 || !idx_ok(ridx)) ? RespSlvErr : RespOkay;
    end else if (r_state_q == StRData && i_rready) begin
      rcnt_q <= rcnt_q + 8'd1;
    end
  end

  // ---------------- registers, timer, interrupts ----------------
  logic tick;
  assign tick = (pcnt_q == prescale_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q     <= '0;
      mtime_q    <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      irq_en_q   <= '0;
      irq_q      <= '0;
      for (int i = 0; i < int'(NUM_TIMERS); i++) cmp_q[i] <= '1;
    end else begin
      pcnt_q <= tick ? '0 : pcnt_q + 16'd1;
      if (wr_en && widx_q == IdxW'(3)) begin
        pcnt_q     <= '0;
        prescale_q <= wr_word[15:0];
        irq_en_q   <= wr_word[16 +: NUM_TIMERS];
      end
      // A write to MTIME swallows a coincident tick.
      if (wr_en && widx_q == IdxW'(2)) mtime_q <= wr_word;
      else if (tick)                   mtime_q <= mtime_q + 64'd1;
      if (wr_en && widx_q == IdxW'(1)) gpio_q <= wr_word[GPIO_WIDTH-1:0];
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
        if (wr_en && widx_q == IdxW'(4 + i)) cmp_q[i] <= wr_word;
        irq_q[i] <= irq_en_q[i] & (mtime_q >= cmp_q[i]);
      end
    end
  end

  assign o_gpio      = gpio_q;
  assign o_timer_irq = irq_q;

endmodule
